// File: rtl/ram_rd_stream.sv
// ram_rd_stream: read-side streamer placed directly after a single-bank RAM
// that has a 1-cycle read latency and a registered data output.
//
// A (base, length) command is accepted in IDLE. The block then issues
// sequential reads starting at base. Addresses wrap naturally at the RAM
// depth. Each returned word goes into a 2-entry skid FIFO, and the FIFO head
// is presented as a valid/ready stream. Reads are throttled by a credit
// count: FIFO occupancy plus the read in flight, less the word leaving this
// cycle. Because of that limit, a returning word always finds a free FIFO
// slot, even under consumer back-pressure. With out_ready held high the
// block sustains one word per cycle.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   cfg_start       command request (accepted when cfg_ready is high)
//   cfg_base        first read address of the command
//   cfg_len         number of words to read (0..SRAM_WORD)
//   cfg_ready       high while IDLE
//   done            1-cycle pulse once the last word of a command is consumed
//   ram_read_en     read strobe to the RAM
//   ram_addr_r      read address to the RAM (holds its value while not reading)
//   ram_data_out    RAM read data, valid the cycle after ram_read_en
//   out_valid       stream word valid
//   out_ready       consumer ready
//   out_data        stream word (FIFO head)

module ram_rd_stream_chk (
    input logic       clk,
    input logic       rst_n,
    input logic       push,
    input logic       pop,
    input logic [1:0] occ
);
    // A push must never land in a full FIFO, and a pop needs a stored word.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (occ == 2'd2)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && (occ == 2'd0)));
    a_occ_range: assert property (@(posedge clk) disable iff (!rst_n)
        occ != 2'd3);
endmodule

module ram_rd_stream #(
    parameter int SRAM_WIDTH      = 256,
    parameter int SRAM_WORD       = 64,
    parameter int SRAM_ADDR_WIDTH = $clog2(SRAM_WORD),
    parameter int LEN_WIDTH       = SRAM_ADDR_WIDTH + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_start,
    input  logic [SRAM_ADDR_WIDTH-1:0] cfg_base,
    input  logic [LEN_WIDTH-1:0]       cfg_len,
    output logic                       cfg_ready,
    output logic                       done,
    output logic                       ram_read_en,
    output logic [SRAM_ADDR_WIDTH-1:0] ram_addr_r,
    input  logic [SRAM_WIDTH-1:0]      ram_data_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SRAM_WIDTH-1:0]      out_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                     state_r;
    logic [SRAM_ADDR_WIDTH-1:0] base_r;
    logic [SRAM_ADDR_WIDTH-1:0] addr_last_r;
    logic [LEN_WIDTH-1:0]       len_r;
    logic [LEN_WIDTH-1:0]       issue_cnt_r;
    logic [LEN_WIDTH-1:0]       pop_cnt_r;
    logic                       inflight_r;
    logic                       done_r;
    logic [SRAM_WIDTH-1:0]      fifo_mem_r [2];
    logic                       wr_ptr_r;
    logic                       rd_ptr_r;
    logic [1:0]                 occ_r;

    logic                       pop_s;
    logic [2:0]                 credit_s;
    logic                       rd_en_s;
    logic [SRAM_ADDR_WIDTH-1:0] addr_next_s;

    assign out_valid = (occ_r != 2'd0);
    assign pop_s     = out_valid && out_ready;
    assign out_data  = fifo_mem_r[rd_ptr_r];
    assign cfg_ready = (state_r == ST_IDLE);
    assign done      = done_r;

    // Words that will still occupy the FIFO after this edge: stored + in flight - leaving.
    assign credit_s    = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    // Truncating the sum to the address width gives the wrap from SRAM_WORD-1 to 0.
    assign addr_next_s = base_r + issue_cnt_r[SRAM_ADDR_WIDTH-1:0];

    // Read strobe: only in RUN, and only while the FIFO has room for the returning word.
    always_comb begin
        rd_en_s = 1'b0;
        if ((state_r == ST_RUN) && (credit_s < 3'd2)) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
    end

    assign ram_read_en = rd_en_s;
    assign ram_addr_r  = rd_en_s ? addr_next_s : addr_last_r;

    // Command FSM: accept, issue count, consume count, and the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            base_r      <= '0;
            len_r       <= '0;
            issue_cnt_r <= '0;
            pop_cnt_r   <= '0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cfg_start) begin
                        base_r      <= cfg_base;
                        len_r       <= cfg_len;
                        issue_cnt_r <= '0;
                        pop_cnt_r   <= '0;
                        if (cfg_len != '0) begin
                            state_r <= ST_RUN;
                        end else begin
                            done_r <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (rd_en_s) begin
                        issue_cnt_r <= issue_cnt_r + LEN_WIDTH'(1);
                        if ((issue_cnt_r + LEN_WIDTH'(1)) == len_r) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                    if (pop_s) begin
                        pop_cnt_r <= pop_cnt_r + LEN_WIDTH'(1);
                    end
                end
                ST_DRAIN: begin
                    // done is registered on the final pop so it is seen the cycle after.
                    if (pop_s) begin
                        pop_cnt_r <= pop_cnt_r + LEN_WIDTH'(1);
                        if ((pop_cnt_r + LEN_WIDTH'(1)) == len_r) begin
                            done_r <= 1'b1;
                        end
                    end
                    if (pop_cnt_r == len_r) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Read pipeline: the in-flight flag and the held address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r  <= 1'b0;
            addr_last_r <= '0;
        end else begin
            inflight_r <= rd_en_s;
            if (rd_en_s) begin
                addr_last_r <= addr_next_s;
            end
        end
    end

    // Skid FIFO: push returning RAM data, pop on stream handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem_r[0] <= '0;
            fifo_mem_r[1] <= '0;
            wr_ptr_r      <= 1'b0;
            rd_ptr_r      <= 1'b0;
            occ_r         <= 2'd0;
        end else begin
            if (inflight_r) begin
                fifo_mem_r[wr_ptr_r] <= ram_data_out;
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            occ_r <= occ_r + {1'b0, inflight_r} - {1'b0, pop_s};
        end
    end

    ram_rd_stream_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_r),
        .pop   (pop_s),
        .occ   (occ_r)
    );

endmodule

// File: tb/tb_ram_rd_stream.sv
// Directed testbench for ram_rd_stream. It includes a behavioural 1-cycle RAM
// model with known contents and a scoreboard of expected stream words.

module tb_ram_rd_stream;

    logic         clk;
    logic         rst_n;
    logic         cfg_start;
    logic [5:0]   cfg_base;
    logic [6:0]   cfg_len;
    logic         cfg_ready;
    logic         done;
    logic         ram_read_en;
    logic [5:0]   ram_addr_r;
    logic [255:0] ram_data_out;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_data;

    int n_checks = 0;
    int n_err    = 0;
    int n_reads  = 0;
    int n_pops   = 0;
    int n_done   = 0;
    logic [255:0] exp_q [$];
    int           addr_log [$];

    ram_rd_stream dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_start    (cfg_start),
        .cfg_base     (cfg_base),
        .cfg_len      (cfg_len),
        .cfg_ready    (cfg_ready),
        .done         (done),
        .ram_read_en  (ram_read_en),
        .ram_addr_r   (ram_addr_r),
        .ram_data_out (ram_data_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] word_at(input int a);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(a);
        return {8{w}};
    endfunction

    // RAM model: registered read data, one cycle after the strobe.
    initial ram_data_out = '0;
    always @(posedge clk) begin
        if (ram_read_en) ram_data_out <= word_at(int'(ram_addr_r));
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Mid-cycle sample: log reads, score popped words, count done pulses.
    task automatic sample();
        @(negedge clk);
        if (rst_n) begin
            if (ram_read_en) begin
                n_reads++;
                addr_log.push_back(int'(ram_addr_r));
            end
            if (out_valid && out_ready) begin
                n_pops++;
                if (exp_q.size() == 0) chk("unexpected_pop", out_data, '0);
                else chk("stream_data", out_data, exp_q.pop_front());
            end
            if (done) n_done++;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input int base, input int len);
        int i;
        i = 0;
        while (!cfg_ready && i < 100) begin
            sample();
            advance();
            i++;
        end
        chk("cfg_ready_before_start", cfg_ready, 1'b1);
        addr_log.delete();
        for (int k = 0; k < len; k++) exp_q.push_back(word_at((base + k) % 64));
        cfg_start = 1'b1;
        cfg_base  = 6'(base);
        cfg_len   = 7'(len);
        sample();
        advance();
        cfg_start = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            sample();
            got = done;
            advance();
        end
        chk("done_seen", got, 1'b1);
    endtask

    task automatic chk_addrs(input string tag, input int base, input int len);
        chk({tag, "_nreads"}, addr_log.size(), len);
        for (int k = 0; k < len && k < addr_log.size(); k++)
            chk({tag, "_addr"}, addr_log[k], (base + k) % 64);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, d0;
        rst_n     = 1'b0;
        cfg_start = 1'b0;
        cfg_base  = '0;
        cfg_len   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cfg_ready", cfg_ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_read_en", ram_read_en, 1'b0);
        chk("rst_addr", ram_addr_r, 6'd0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        advance();

        // T1: base 0, len 4, full-rate consumer; exact cycle timing.
        start_cmd(0, 4);
        for (int k = 1; k <= 7; k++) begin
            sample();
            chk("t1_read_en", ram_read_en, (k <= 4));
            if (k <= 4) chk("t1_addr", ram_addr_r, 6'(k - 1));
            chk("t1_out_valid", out_valid, (k >= 3 && k <= 6));
            chk("t1_done", done, (k == 7));
            chk("t1_cfg_ready", cfg_ready, 1'b0);
            if (k == 3) chk("t1_first_word", out_data, word_at(0));
            advance();
        end
        sample();
        chk("t1_done_low", done, 1'b0);
        chk("t1_cfg_ready_back", cfg_ready, 1'b1);
        advance();
        chk_addrs("t1", 0, 4);
        chk("t1_drained", exp_q.size(), 0);

        // T2: address wrap 62,63,0,1.
        start_cmd(62, 4);
        run_until_done(40);
        chk_addrs("t2", 62, 4);
        chk("t2_drained", exp_q.size(), 0);

        // T3: consumer stalls C3..C10; only two reads may be outstanding.
        r0 = n_reads;
        start_cmd(10, 8);
        sample(); advance();
        sample(); advance();
        out_ready = 1'b0;
        for (int k = 3; k <= 10; k++) begin
            sample();
            chk("t3_read_en_stall", ram_read_en, 1'b0);
            chk("t3_valid_stall", out_valid, 1'b1);
            chk("t3_data_held", out_data, word_at(10));
            advance();
        end
        chk("t3_reads_in_stall", n_reads - r0, 2);
        out_ready = 1'b1;
        run_until_done(40);
        chk_addrs("t3", 10, 8);
        chk("t3_drained", exp_q.size(), 0);

        // T4: random back-pressure.
        start_cmd(40, 16);
        begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 300 && !got; i++) begin
                out_ready = 1'($urandom_range(0, 1));
                sample();
                got = done;
                advance();
            end
            chk("t4_done_seen", got, 1'b1);
        end
        out_ready = 1'b1;
        chk_addrs("t4", 40, 16);
        chk("t4_drained", exp_q.size(), 0);

        // T5a: zero-length command.
        r0 = n_reads;
        start_cmd(5, 0);
        sample();
        chk("t5_len0_done", done, 1'b1);
        chk("t5_len0_read_en", ram_read_en, 1'b0);
        chk("t5_len0_cfg_ready", cfg_ready, 1'b1);
        advance();
        sample();
        chk("t5_len0_done_low", done, 1'b0);
        advance();
        chk("t5_len0_no_reads", n_reads - r0, 0);

        // T5b: cfg_start during RUN is ignored.
        start_cmd(20, 4);
        sample(); advance();
        cfg_start = 1'b1;
        cfg_base  = 6'd0;
        cfg_len   = 7'd2;
        sample(); advance();
        cfg_start = 1'b0;
        run_until_done(40);
        d0 = n_done;
        r0 = n_reads;
        for (int k = 0; k < 6; k++) begin
            sample();
            advance();
        end
        chk_addrs("t5", 20, 4);
        chk("t5_no_extra_done", n_done - d0, 0);
        chk("t5_no_extra_reads", n_reads - r0, 0);
        chk("t5_drained", exp_q.size(), 0);

        // T6: asynchronous reset mid-command, then a clean new command.
        r0 = n_pops;
        start_cmd(0, 8);
        for (int i = 0; i < 40 && (n_pops - r0) < 3; i++) begin
            sample();
            advance();
        end
        chk("t6_three_pops", n_pops - r0, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_cfg_ready", cfg_ready, 1'b1);
        chk("t6_done", done, 1'b0);
        chk("t6_read_en", ram_read_en, 1'b0);
        chk("t6_addr", ram_addr_r, 6'd0);
        chk("t6_out_valid", out_valid, 1'b0);
        chk("t6_out_data", out_data, '0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        advance();
        d0 = n_done;
        start_cmd(30, 3);
        run_until_done(40);
        chk_addrs("t6", 30, 3);
        chk("t6_drained", exp_q.size(), 0);
        chk("t6_one_done", n_done - d0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
